// File: rtl/axi_10g_ethernet_0_tx_pkg.sv
// axi_10g_ethernet_0_tx_pkg: shared widths, source IDs and FSM states for the TX arbiter
package axi_10g_ethernet_0_tx_pkg;
    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    typedef logic [1:0] src_id_t;
    localparam src_id_t SRC_NONE        = 2'd0;
    localparam src_id_t SRC_ARP_REPLY   = 2'd1;
    localparam src_id_t SRC_ARP_REQUEST = 2'd2;
    localparam src_id_t SRC_IP_TX       = 2'd3;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;
    // Round-robin successor; NONE behaves like "after ip_tx" so arp_reply comes first
    function automatic src_id_t next_src(input src_id_t id);
        return (id == SRC_IP_TX) ? SRC_ARP_REPLY : id + 2'd1;
    endfunction
endpackage

// File: rtl/axi_10g_ethernet_0_tx_arbiter_if.sv
// axi_10g_ethernet_0_tx_arbiter_if: 64-bit AXI-Stream link used by every arbiter port
interface axi_10g_ethernet_0_tx_arbiter_if;
    import axi_10g_ethernet_0_tx_pkg::*;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;
    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axi_10g_ethernet_0_rr_arbiter.sv
// axi_10g_ethernet_0_rr_arbiter: combinational round-robin pick among three sources
module axi_10g_ethernet_0_rr_arbiter
    import axi_10g_ethernet_0_tx_pkg::*;
(
    input  logic [2:0] req,
    input  src_id_t    last_served,
    output src_id_t    winner
);
    src_id_t c0, c1, c2;
    function automatic logic wants(input logic [2:0] r, input src_id_t id);
        return (id == SRC_ARP_REPLY) ? r[0] : (id == SRC_ARP_REQUEST) ? r[1] : (id == SRC_IP_TX) ? r[2] : 1'b0;
    endfunction
    always_comb begin
        c0 = next_src(last_served);
        c1 = next_src(c0);
        c2 = next_src(c1);
        winner = wants(req, c0) ? c0 : wants(req, c1) ? c1 : wants(req, c2) ? c2 : SRC_NONE;
    end
endmodule

// File: rtl/axi_10g_ethernet_0_tx_arbiter.sv
// axi_10g_ethernet_0_tx_arbiter: frame-level round-robin merge of ARP reply, ARP request and IP TX into the MAC
module axi_10g_ethernet_0_tx_arbiter
    import axi_10g_ethernet_0_tx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES     = 1
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic                                   arp_reply_en,
    axi_10g_ethernet_0_tx_arbiter_if.slave         arp_reply,
    input  logic                                   arp_request_en,
    axi_10g_ethernet_0_tx_arbiter_if.slave         arp_request,
    input  logic                                   ip_tx_en,
    axi_10g_ethernet_0_tx_arbiter_if.slave         ip_tx,
    axi_10g_ethernet_0_tx_arbiter_if.master        m_axis,
    output src_id_t                                grant_id,
    output logic                                   timeout_err
);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t            state, state_n;
    src_id_t           grant_n, last_served, last_n, rr_last, winner;
    logic [WD_W-1:0]   wd_cnt, wd_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic              terr_n, frame_end, timeout;

    assign m_axis.tdata  = grant_id == SRC_ARP_REPLY ? arp_reply.tdata :
                           grant_id == SRC_ARP_REQUEST ? arp_request.tdata : ip_tx.tdata;
    assign m_axis.tkeep  = grant_id == SRC_ARP_REPLY ? arp_reply.tkeep :
                           grant_id == SRC_ARP_REQUEST ? arp_request.tkeep : ip_tx.tkeep;
    assign m_axis.tvalid = grant_id == SRC_ARP_REPLY ? arp_reply.tvalid :
                           grant_id == SRC_ARP_REQUEST ? arp_request.tvalid :
                           grant_id == SRC_IP_TX ? ip_tx.tvalid : 1'b0;
    assign m_axis.tlast  = grant_id == SRC_ARP_REPLY ? arp_reply.tlast :
                           grant_id == SRC_ARP_REQUEST ? arp_request.tlast :
                           grant_id == SRC_IP_TX ? ip_tx.tlast : 1'b0;

    assign arp_reply.tready   = grant_id == SRC_ARP_REPLY && m_axis.tready;
    assign arp_request.tready = grant_id == SRC_ARP_REQUEST && m_axis.tready;
    assign ip_tx.tready       = grant_id == SRC_IP_TX && m_axis.tready;

    assign frame_end = m_axis.tvalid && m_axis.tready && m_axis.tlast;
    assign timeout   = !m_axis.tvalid && wd_cnt == WD_LAST;
    // With no gap the next winner is picked on the closing beat, ranked after the source just finishing
    assign rr_last   = state == ST_SEND ? grant_id : last_served;

    axi_10g_ethernet_0_rr_arbiter u_rr (
        .req         ({ip_tx_en, arp_request_en, arp_reply_en}),
        .last_served (rr_last),
        .winner      (winner)
    );

    always_comb begin
        state_n = state;
        grant_n = grant_id;
        last_n  = last_served;
        wd_n    = wd_cnt;
        gap_n   = gap_cnt;
        terr_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (winner != SRC_NONE) begin
                    state_n = ST_SEND;
                    grant_n = winner;
                    wd_n    = '0;
                end
            end
            ST_SEND: begin
                if (frame_end || timeout) begin
                    last_n  = grant_id;
                    terr_n  = timeout;
                    wd_n    = '0;
                    gap_n   = '0;
                    state_n = GAP_CYCLES != 0 ? ST_GAP : (winner != SRC_NONE ? ST_SEND : ST_IDLE);
                    grant_n = GAP_CYCLES != 0 ? SRC_NONE : winner;
                end else begin
                    wd_n = m_axis.tvalid ? '0 : wd_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                gap_n   = gap_cnt + 1'b1;
                state_n = gap_cnt == GAP_LAST ? ST_IDLE : ST_GAP;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= ST_IDLE;
            grant_id    <= SRC_NONE;
            last_served <= SRC_IP_TX;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            grant_id    <= grant_n;
            last_served <= last_n;
            wd_cnt      <= wd_n;
            gap_cnt     <= gap_n;
            timeout_err <= terr_n;
        end
    end
endmodule

// File: tb/tb_axi_10g_ethernet_0_tx_arbiter.sv
// tb_axi_10g_ethernet_0_tx_arbiter: scoreboard bench for the TX arbiter (default gap) plus a zero-gap instance
module tb_axi_10g_ethernet_0_tx_arbiter;
    import axi_10g_ethernet_0_tx_pkg::*;
    typedef struct packed {
        logic [1:0]  src;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_ready = 1'b1;
    logic       tog = 1'b0;
    logic       z_on = 1'b0;
    logic [1:0] grant_id, grant_id0;
    logic       timeout_err, timeout_err0;
    int         n_chk = 0;
    int         n_err = 0;
    int         fid = 0;
    beat_t      exp_q[$];
    logic [1:0] glog[$];

    always #5 clk = ~clk;

    axi_10g_ethernet_0_tx_arbiter_if if_rep ();
    axi_10g_ethernet_0_tx_arbiter_if if_req ();
    axi_10g_ethernet_0_tx_arbiter_if if_ip ();
    axi_10g_ethernet_0_tx_arbiter_if if_m ();
    axi_10g_ethernet_0_tx_arbiter_if z_rep ();
    axi_10g_ethernet_0_tx_arbiter_if z_req ();
    axi_10g_ethernet_0_tx_arbiter_if z_ip ();
    axi_10g_ethernet_0_tx_arbiter_if z_m ();

    // One frame-queue driver per source; en follows queue occupancy unless forced
    for (genvar g = 0; g < 3; g++) begin : drv
        beat_t       q[$];
        logic        en_force, en, valid, last, rdy, acc;
        logic [63:0] data;
        logic [7:0]  keep;
        assign rdy = (g == 0) ? if_rep.tready : (g == 1) ? if_req.tready : if_ip.tready;
        initial begin
            en = 1'b0; valid = 1'b0; last = 1'b0; data = '0; keep = '0; acc = 1'b0;
            forever begin
                @(negedge clk);
                acc = valid && rdy;
                @(posedge clk);
                #1;
                if (acc && q.size() != 0) void'(q.pop_front());
                valid = q.size() != 0;
                en = en_force || valid;
                if (valid) begin
                    data = q[0].data;
                    keep = q[0].keep;
                    last = q[0].last;
                end
            end
        end
    end

    assign if_rep.tdata  = drv[0].data;
    assign if_rep.tkeep  = drv[0].keep;
    assign if_rep.tvalid = drv[0].valid;
    assign if_rep.tlast  = drv[0].last;
    assign if_req.tdata  = drv[1].data;
    assign if_req.tkeep  = drv[1].keep;
    assign if_req.tvalid = drv[1].valid;
    assign if_req.tlast  = drv[1].last;
    assign if_ip.tdata   = drv[2].data;
    assign if_ip.tkeep   = drv[2].keep;
    assign if_ip.tvalid  = drv[2].valid;
    assign if_ip.tlast   = drv[2].last;
    assign if_m.tready   = m_ready;

    assign z_rep.tdata  = 64'h1111;
    assign z_rep.tkeep  = 8'hFF;
    assign z_rep.tvalid = z_on;
    assign z_rep.tlast  = 1'b1;
    assign z_req.tdata  = 64'h2222;
    assign z_req.tkeep  = 8'hFF;
    assign z_req.tvalid = z_on;
    assign z_req.tlast  = 1'b1;
    assign z_ip.tdata   = '0;
    assign z_ip.tkeep   = '0;
    assign z_ip.tvalid  = 1'b0;
    assign z_ip.tlast   = 1'b0;
    assign z_m.tready   = 1'b1;

    axi_10g_ethernet_0_tx_arbiter dut (
        .aclk           (clk),
        .areset         (rst),
        .arp_reply_en   (drv[0].en),
        .arp_reply      (if_rep),
        .arp_request_en (drv[1].en),
        .arp_request    (if_req),
        .ip_tx_en       (drv[2].en),
        .ip_tx          (if_ip),
        .m_axis         (if_m),
        .grant_id       (grant_id),
        .timeout_err    (timeout_err)
    );

    axi_10g_ethernet_0_tx_arbiter #(.GAP_CYCLES(0)) dut0 (
        .aclk           (clk),
        .areset         (rst),
        .arp_reply_en   (z_on),
        .arp_reply      (z_rep),
        .arp_request_en (z_on),
        .arp_request    (z_req),
        .ip_tx_en       (1'b0),
        .ip_tx          (z_ip),
        .m_axis         (z_m),
        .grant_id       (grant_id0),
        .timeout_err    (timeout_err0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int s, input int n, input logic [7:0] lk, input int n_exp);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.src  = 2'(s + 1);
            b.data = {8'(s + 1), 8'(fid), 16'(i), 32'($urandom)};
            b.keep = (i == n - 1) ? lk : 8'hFF;
            b.last = i == n - 1;
            case (s)
                0: drv[0].q.push_back(b);
                1: drv[1].q.push_back(b);
                default: drv[2].q.push_back(b);
            endcase
            if (i < n_exp) exp_q.push_back(b);
        end
        fid++;
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = exp_q.size() == 0 && drv[0].q.size() == 0 && drv[1].q.size() == 0 &&
                   drv[2].q.size() == 0 && grant_id == 2'd0;
        end
        check("drain", done, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_grant(input logic [1:0] id, input int budget);
        for (int i = 0; i < budget && grant_id != id; i++) @(negedge clk);
        check("wait_grant", grant_id, id);
    endtask

    function automatic logic [63:0] glog_code();
        logic [63:0] c = '0;
        foreach (glog[i]) c = {c[59:0], 2'b00, glog[i]};
        return c;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = tog ? ~m_ready : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard per accepted beat and logs every grant_id change
    initial begin
        logic [1:0] last_g;
        beat_t      e;
        last_g = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst && if_m.tvalid && if_m.tready) begin
                check("sb_has_exp", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_tdata", if_m.tdata, e.data);
                    check("m_tkeep", if_m.tkeep, e.keep);
                    check("m_tlast", if_m.tlast, e.last);
                    check("beat_grant", grant_id, e.src);
                end
            end
            if (grant_id !== last_g) begin
                glog.push_back(grant_id);
                last_g = grant_id;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  k;
        bit  ok;
        drv[0].en_force = 1'b0;
        drv[1].en_force = 1'b0;
        drv[2].en_force = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", grant_id, 0);
        check("rst_tvalid", if_m.tvalid, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_tready", {if_rep.tready, if_req.tready, if_ip.tready}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // all three request together: 1,2,3,1 with idle between frames
        glog.delete();
        push_frame(0, 2, 8'hFF, 2);
        push_frame(1, 3, 8'h3F, 3);
        push_frame(2, 2, 8'h01, 2);
        push_frame(0, 2, 8'h7F, 2);
        drain(300);
        check("rr_order", glog_code(), 64'h10203010);

        // 8-beat ip_tx frame under 1/0 backpressure
        glog.delete();
        tog = 1'b1;
        push_frame(2, 8, 8'h0F, 8);
        drain(300);
        tog = 1'b0;
        check("stall_grant_held", glog_code(), 64'h30);

        // watchdog revokes a silent arp_reply; pending arp_request follows
        glog.delete();
        drv[0].en_force = 1'b1;
        push_frame(1, 1, 8'hFF, 1);
        wait_grant(2'd1, 20);
        for (k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (timeout_err) break;
        end
        drv[0].en_force = 1'b0;
        check("to_cycles", k, 1024);
        check("to_grant_clr", grant_id, 0);
        @(negedge clk);
        check("to_pulse_end", timeout_err, 0);
        drain(100);
        check("to_then_req", glog_code(), 64'h1020);

        // one-cycle arp_request pulse during an ip_tx frame is never granted
        glog.delete();
        push_frame(2, 6, 8'hFF, 6);
        wait_grant(2'd3, 20);
        drv[1].en_force = 1'b1;
        @(negedge clk);
        drv[1].en_force = 1'b0;
        drain(100);
        check("pulse_ignored", glog_code(), 64'h30);

        // reset mid-frame: arp_request served first so last_served differs from its reset value
        push_frame(1, 1, 8'hFF, 1);
        drain(100);
        push_frame(0, 6, 8'hFF, 3);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = if_m.tvalid && if_m.tready && if_m.tdata[47:32] == 16'd2;
        end
        check("rst_sync", ok, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        drv[0].q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_tvalid", if_m.tvalid, 0);
        check("post_rst_grant", grant_id, 0);
        glog.delete();
        push_frame(0, 1, 8'hFF, 1);
        push_frame(2, 1, 8'hFF, 1);
        drain(100);
        check("post_rst_order", glog_code(), 64'h1030);

        // zero-gap instance: grants alternate with no idle cycle
        z_on = 1'b1;
        for (int i = 0; i < 10 && grant_id0 == 2'd0; i++) @(negedge clk);
        check("z_first", grant_id0, 1);
        check("z_first_tvalid", z_m.tvalid, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("z_grant", grant_id0, (i % 2 == 0) ? 2 : 1);
            check("z_tvalid", z_m.tvalid, 1);
        end
        z_on = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
